// File: rtl/stall_ctrl_if.sv
// stall_ctrl_if: hazard/branch requests in, pipeline enables and debug counters out.
interface stall_ctrl_if #(parameter int CNT_W = 16);
    logic             stop;
    logic             branch_taken;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             ex_mem_flush;
    logic             busy;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;
    modport master(
        output stop, branch_taken,
        input  pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_flush, busy, stall_count, flush_count
    );
    modport slave(
        input  stop, branch_taken,
        output pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_flush, busy, stall_count, flush_count
    );
endinterface

// File: rtl/stall_ctrl.sv
// stall_ctrl: stretches a load-use stop into a STALL_CYCLES freeze; taken branches flush and win.
module stall_ctrl #(
    parameter int STALL_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input logic         clk,
    input logic         rst,
    stall_ctrl_if.slave bus
);
    typedef enum logic {RUN, STALL} state_t;
    state_t           state;
    logic [1:0]       rem;
    logic             busy;
    logic             load_use;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    // A branch squashes the stalled instruction, so it overrides any load-use freeze.
    assign load_use         = !rst && !bus.branch_taken && (state == STALL || bus.stop);
    assign bus.pc_write     = !rst && !load_use;
    assign bus.if_id_write  = !rst && !load_use;
    assign bus.if_id_flush  = rst || bus.branch_taken;
    assign bus.id_ex_bubble = rst || bus.branch_taken || load_use;
    assign bus.ex_mem_flush = !rst && bus.branch_taken;
    assign bus.busy         = busy;
    assign bus.stall_count  = stall_cnt;
    assign bus.flush_count  = flush_cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            rem       <= '0;
            busy      <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (bus.branch_taken) begin
                state <= RUN;
                rem   <= '0;
                busy  <= 1'b0;
            end else if (state == STALL) begin
                if (rem == 2'd0) begin
                    state <= RUN;
                    busy  <= 1'b0;
                end else begin
                    rem <= rem - 2'd1;
                end
            end else if (bus.stop && STALL_CYCLES > 1) begin
                state <= STALL;
                rem   <= 2'(STALL_CYCLES - 2);
                busy  <= 1'b1;
            end
            if (load_use && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
            if (bus.branch_taken && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_stall_ctrl.sv
// tb_stall_ctrl: directed checks on three stall_ctrl instances (STALL_CYCLES 1/3/4) sharing stimulus.
module tb_stall_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stop = 1'b0;
    logic br = 1'b0;
    int checks = 0;
    int failures = 0;
    always #5 clk = ~clk;
    stall_ctrl_if #(.CNT_W(4)) if1 ();
    stall_ctrl_if              if3 ();
    stall_ctrl_if              if4 ();
    assign if1.stop = stop;
    assign if1.branch_taken = br;
    assign if3.stop = stop;
    assign if3.branch_taken = br;
    assign if4.stop = stop;
    assign if4.branch_taken = br;
    stall_ctrl #(.STALL_CYCLES(1), .CNT_W(4)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
    stall_ctrl #(.STALL_CYCLES(3))            u3 (.clk(clk), .rst(rst), .bus(if3.slave));
    stall_ctrl #(.STALL_CYCLES(4))            u4 (.clk(clk), .rst(rst), .bus(if4.slave));

    task automatic do_reset();
        rst = 1'b1; stop = 1'b0; br = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; stop = 1'b0; br = 1'b0;
        #1;
        checks++; if (if1.pc_write !== 1'b0) begin failures++; $display("FAIL rst_pc_write got=%0b exp=0", if1.pc_write); end
        checks++; if (if1.if_id_write !== 1'b0) begin failures++; $display("FAIL rst_if_id_write got=%0b exp=0", if1.if_id_write); end
        checks++; if (if1.id_ex_bubble !== 1'b1) begin failures++; $display("FAIL rst_bubble got=%0b exp=1", if1.id_ex_bubble); end
        checks++; if (if1.if_id_flush !== 1'b1) begin failures++; $display("FAIL rst_if_id_flush got=%0b exp=1", if1.if_id_flush); end
        @(negedge clk);
        br = 1'b1;
        #1;
        checks++; if (if3.ex_mem_flush !== 1'b0) begin failures++; $display("FAIL rst_ex_mem_flush got=%0b exp=0", if3.ex_mem_flush); end
        checks++; if (if3.pc_write !== 1'b0) begin failures++; $display("FAIL rst_pc_write_br got=%0b exp=0", if3.pc_write); end
        checks++; if (if3.stall_count !== 16'd0 || if3.flush_count !== 16'd0) begin failures++; $display("FAIL rst_counts got=%0d/%0d exp=0/0", if3.stall_count, if3.flush_count); end
        @(negedge clk);
        rst = 1'b0; br = 1'b0;
        #1;
        checks++; if (if3.pc_write !== 1'b1 || if3.if_id_write !== 1'b1) begin failures++; $display("FAIL post_rst_write got=%0b%0b exp=11", if3.pc_write, if3.if_id_write); end
        checks++; if (if3.busy !== 1'b0 || if3.id_ex_bubble !== 1'b0 || if3.if_id_flush !== 1'b0) begin failures++; $display("FAIL post_rst_idle got=%0b%0b%0b exp=000", if3.busy, if3.id_ex_bubble, if3.if_id_flush); end
        checks++; if (if3.flush_count !== 16'd0) begin failures++; $display("FAIL post_rst_flush_count got=%0d exp=0", if3.flush_count); end
        @(negedge clk);
    endtask

    task automatic test_single_stall();
        do_reset();
        stop = 1'b1;
        #1;
        checks++; if (if1.pc_write !== 1'b0 || if1.if_id_write !== 1'b0) begin failures++; $display("FAIL single_freeze got=%0b%0b exp=00", if1.pc_write, if1.if_id_write); end
        checks++; if (if1.id_ex_bubble !== 1'b1 || if1.ex_mem_flush !== 1'b0) begin failures++; $display("FAIL single_bubble got=%0b%0b exp=10", if1.id_ex_bubble, if1.ex_mem_flush); end
        @(negedge clk);
        stop = 1'b0;
        #1;
        checks++; if (if1.pc_write !== 1'b1 || if1.busy !== 1'b0) begin failures++; $display("FAIL single_resume got=%0b%0b exp=10", if1.pc_write, if1.busy); end
        checks++; if (if1.stall_count !== 4'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", if1.stall_count); end
        @(negedge clk);
    endtask

    task automatic test_multi_stall();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            stop = (k == 0);
            #1;
            checks++; if (if3.pc_write !== (k >= 3)) begin failures++; $display("FAIL multi_pc_write[%0d] got=%0b exp=%0b", k, if3.pc_write, k >= 3); end
            checks++; if (if3.busy !== (k == 1 || k == 2)) begin failures++; $display("FAIL multi_busy[%0d] got=%0b exp=%0b", k, if3.busy, k == 1 || k == 2); end
            @(negedge clk);
        end
        stop = 1'b0;
        checks++; if (if3.stall_count !== 16'd3) begin failures++; $display("FAIL multi_count got=%0d exp=3", if3.stall_count); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 0; k < 6; k++) begin
            stop = 1'b1;
            #1;
            checks++; if (if3.pc_write !== 1'b0) begin failures++; $display("FAIL b2b_pc_write[%0d] got=%0b exp=0", k, if3.pc_write); end
            checks++; if (if3.busy !== (k != 0 && k != 3)) begin failures++; $display("FAIL b2b_busy[%0d] got=%0b exp=%0b", k, if3.busy, k != 0 && k != 3); end
            @(negedge clk);
        end
        stop = 1'b0;
        checks++; if (if3.stall_count !== 16'd6) begin failures++; $display("FAIL b2b_count got=%0d exp=6", if3.stall_count); end
    endtask

    task automatic test_branch_in_stall();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            stop = (k == 0); br = (k == 2);
            #1;
            if (k == 1) begin
                checks++; if (if4.pc_write !== 1'b0 || if4.busy !== 1'b1) begin failures++; $display("FAIL brst_c1 got=%0b%0b exp=01", if4.pc_write, if4.busy); end
            end
            if (k == 2) begin
                checks++; if (if4.pc_write !== 1'b1 || if4.if_id_write !== 1'b1) begin failures++; $display("FAIL brst_c2_write got=%0b%0b exp=11", if4.pc_write, if4.if_id_write); end
                checks++; if (if4.if_id_flush !== 1'b1 || if4.id_ex_bubble !== 1'b1 || if4.ex_mem_flush !== 1'b1) begin failures++; $display("FAIL brst_c2_flush got=%0b%0b%0b exp=111", if4.if_id_flush, if4.id_ex_bubble, if4.ex_mem_flush); end
            end
            if (k >= 3) begin
                checks++; if (if4.busy !== 1'b0 || if4.pc_write !== 1'b1 || if4.id_ex_bubble !== 1'b0) begin failures++; $display("FAIL brst_c%0d_run got=%0b%0b%0b exp=010", k, if4.busy, if4.pc_write, if4.id_ex_bubble); end
            end
            @(negedge clk);
        end
        br = 1'b0;
        checks++; if (if4.stall_count !== 16'd2) begin failures++; $display("FAIL brst_stall_count got=%0d exp=2", if4.stall_count); end
        checks++; if (if4.flush_count !== 16'd1) begin failures++; $display("FAIL brst_flush_count got=%0d exp=1", if4.flush_count); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        stop = 1'b1; br = 1'b1;
        #1;
        checks++; if (if3.pc_write !== 1'b1 || if3.if_id_write !== 1'b1) begin failures++; $display("FAIL simul_write got=%0b%0b exp=11", if3.pc_write, if3.if_id_write); end
        checks++; if (if3.if_id_flush !== 1'b1 || if3.ex_mem_flush !== 1'b1 || if3.id_ex_bubble !== 1'b1) begin failures++; $display("FAIL simul_flush got=%0b%0b%0b exp=111", if3.if_id_flush, if3.ex_mem_flush, if3.id_ex_bubble); end
        @(negedge clk);
        stop = 1'b0; br = 1'b0;
        #1;
        checks++; if (if3.busy !== 1'b0 || if3.pc_write !== 1'b1) begin failures++; $display("FAIL simul_no_stall got=%0b%0b exp=01", if3.busy, if3.pc_write); end
        checks++; if (if3.stall_count !== 16'd0 || if3.flush_count !== 16'd1) begin failures++; $display("FAIL simul_counts got=%0d/%0d exp=0/1", if3.stall_count, if3.flush_count); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (if4.busy !== 1'b1 || if4.pc_write !== 1'b0) begin failures++; $display("FAIL rmid_in_stall got=%0b%0b exp=10", if4.busy, if4.pc_write); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (if4.busy !== 1'b0 || if4.pc_write !== 1'b1 || if4.id_ex_bubble !== 1'b0) begin failures++; $display("FAIL rmid_run got=%0b%0b%0b exp=010", if4.busy, if4.pc_write, if4.id_ex_bubble); end
        checks++; if (if4.stall_count !== 16'd0) begin failures++; $display("FAIL rmid_count got=%0d exp=0", if4.stall_count); end
        @(negedge clk);
    endtask

    task automatic test_saturation();
        do_reset();
        for (int k = 0; k < 20; k++) begin
            stop = 1'b1;
            #1;
            checks++; if (if1.stall_count !== 4'((k > 15) ? 15 : k)) begin failures++; $display("FAIL sat_stall[%0d] got=%0d exp=%0d", k, if1.stall_count, (k > 15) ? 15 : k); end
            @(negedge clk);
        end
        stop = 1'b0;
        checks++; if (if1.stall_count !== 4'd15) begin failures++; $display("FAIL sat_stall_end got=%0d exp=15", if1.stall_count); end
        for (int k = 0; k < 18; k++) begin
            br = 1'b1;
            @(negedge clk);
        end
        br = 1'b0;
        checks++; if (if1.flush_count !== 4'd15 || if1.stall_count !== 4'd15) begin failures++; $display("FAIL sat_flush got=%0d/%0d exp=15/15", if1.flush_count, if1.stall_count); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_stall();
        test_multi_stall();
        test_back_to_back();
        test_branch_in_stall();
        test_simultaneous();
        test_reset_mid_stall();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/stall_ctrl.md
# stall_ctrl

Pipeline stall/flush controller. It consumes the load-use `stop` request from the hazard detection unit and the taken-branch indication from MEM, then drives the pipeline-register and PC enables. It converts a single-cycle `stop` pulse into a programmable-length freeze of PC and IF/ID, with bubble insertion into ID/EX. It also keeps saturating stall and flush event counters for performance debug. It sits between the hazard unit and the PC / IF-ID / ID-EX / EX-MEM registers.

## Interface
Parameters:
- `STALL_CYCLES`, default 1: bubble cycles per load-use hazard; legal range 1..4.
- `CNT_W`, default 16: width of the event counters.

Ports:
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `stop`  in  1  load-use hazard request from the hazard unit (level, combinational).
- `branch_taken`  in  1  taken branch resolved in MEM this cycle.
- `pc_write`  out  1  PC load enable.
- `if_id_write`  out  1  IF/ID register load enable.
- `if_id_flush`  out  1  clear IF/ID to NOP.
- `id_ex_bubble`  out  1  force ID/EX control fields to zero (bubble).
- `ex_mem_flush`  out  1  clear EX/MEM control fields.
- `busy`  out  1  registered; high while in STALL state.
- `stall_count`  out  CNT_W  bubble cycles inserted for load-use, saturating.
- `flush_count`  out  CNT_W  branch flush events, saturating.

## Operation
- FSM states: RUN, STALL. Down-counter `rem` is 2 bits wide and holds the bubble cycles left after the current one.
- RUN, no events: pc_write=1, if_id_write=1, all flush/bubble outputs 0.
- RUN, stop=1, branch_taken=0: same cycle (Mealy) pc_write=0, if_id_write=0, id_ex_bubble=1.
  - If STALL_CYCLES>1: go to STALL with rem=STALL_CYCLES-2.
  - Else: stay in RUN.
- STALL: pc_write=0, if_id_write=0, id_ex_bubble=1. `stop` is ignored.
  - rem==0: go to RUN.
  - Otherwise: decrement rem.
- branch_taken=1 in any state takes priority over stop and over STALL. Same cycle:
  - pc_write=1 (PC takes the branch target), if_id_write=1.
  - if_id_flush=1, id_ex_bubble=1, ex_mem_flush=1.
  - Next state is RUN, rem=0. Any pending stall is abandoned, because the stalled instruction is being squashed.
- stall_count: +1 in every cycle where id_ex_bubble=1 due to a load-use (RUN+stop or STALL) and branch_taken=0. Holds at 2^CNT_W-1.
- flush_count: +1 in every cycle with branch_taken=1. Holds at all-ones.
- Counters never wrap.

## Timing
- Reset (rst high at a clock edge): state=RUN, rem=0, busy=0, stall_count=0, flush_count=0.
- While rst is high, combinational outputs are forced to pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1, ex_mem_flush=0. Inputs are ignored.
- First cycle after rst deasserts: normal RUN behaviour.
- Enable/flush outputs are combinational from state, stop, branch_taken and rst. There is zero latency from stop to freeze.
- `busy` and the counters are registered and update one cycle after the causing event.
- Total freeze length per hazard is exactly STALL_CYCLES cycles, counted from the cycle stop is first seen in RUN.
- A stop that is still high on the first RUN cycle after a stall starts a new stall. This covers back-to-back loads.
- rst asserted mid-STALL: the stall is aborted. The first post-reset cycle is RUN with rem=0.

## Test plan
- Reset: rst=1 for 2 cycles, then 0, with stop=0 and branch=0. Required: during reset pc_write=0, id_ex_bubble=1, if_id_flush=1, counts=0. After reset pc_write=1, if_id_write=1, busy=0.
- Single stall, STALL_CYCLES=1: stop=1 for one cycle. Required: in that cycle pc_write=0, if_id_write=0, id_ex_bubble=1. Next cycle pc_write=1, busy=0, stall_count=1.
- Multi stall, STALL_CYCLES=3: stop pulse of 1 cycle. Required: pc_write=0 for exactly 3 consecutive cycles, busy=1 for 2 cycles, stall_count=3.
- Branch during stall, STALL_CYCLES=4: stop at cycle 0, branch_taken at cycle 2. Required:
  - Cycle 2: pc_write=1, if_id_flush=1, id_ex_bubble=1, ex_mem_flush=1.
  - Cycle 3: RUN, busy=0.
  - stall_count=2, flush_count=1.
- Simultaneous: stop=1 and branch_taken=1 in the same RUN cycle. Required: flush behaviour only, no STALL entry, stall_count unchanged, flush_count+1.
- Saturation, CNT_W=4: 20 back-to-back stalls with STALL_CYCLES=1. Required: stall_count stops at 15 and never returns to 0.
